cfo_estimate: RTL and testbench
===============================

Name: cfo_estimate

Overview:
- Sits directly downstream of the phase (atan) stage in the short-preamble path.
- Averages 2^AVG_SHIFT phase samples of the delayed autocorrelation and divides by the lag to give a per-sample carrier-frequency-offset increment.
- Then generates a wrapped derotation phase ramp, one step per data sample, for the rotator.
- Phase units everywhere: radians scaled by 512, range [-PI, PI).

Parameters:
- AVG_SHIFT, 4, log2 of the number of phase samples averaged (16).
- LAG_SHIFT, 4, log2 of the autocorrelation lag in samples (16).
- PI, 1608, pi scaled by 512; 2*PI = 3216.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  clock enable; when low all state and outputs hold and input strobes are ignored.
- start  in  1  one-cycle pulse; begins a new estimate.
- phase_in  in  16  signed phase from the phase stage.
- phase_stb  in  1  phase_in valid.
- sample_stb  in  1  one data sample passed to the rotator; advances the ramp.
- busy  out  1  high in ACCUM and DIVIDE.
- cfo_est  out  16  signed per-sample phase increment.
- est_valid  out  1  one-cycle pulse when cfo_est updates.
- ramp_phase  out  16  signed derotation phase, range [-PI, PI).
- ramp_stb  out  1  ramp_phase valid.

Behaviour:
- Reset: state IDLE; sum = 0; count = 0; ramp accumulator = 0. All outputs 0.
- States: IDLE, ACCUM, DIVIDE, TRACK.
- start (enabled) from any state:
  - Next state ACCUM; sum and count cleared; ramp accumulator cleared.
  - start has priority: a phase_stb in the same cycle is discarded.
- IDLE:
  - phase_stb and sample_stb are ignored.
  - ramp_stb stays 0.
- ACCUM:
  - Each enabled phase_stb: sum += sign-extend(phase_in); count += 1.
  - sum width is 16+AVG_SHIFT+1 bits signed, so no overflow is possible.
  - When the strobe that makes count = 2^AVG_SHIFT is accepted (cycle t), state becomes DIVIDE at t+1.
  - sample_stb is ignored; ramp_stb stays 0.
- DIVIDE (one cycle):
  - cfo_est <= (sum + 2^(S-1)) >>> S, where S = AVG_SHIFT+LAG_SHIFT. This is arithmetic shift, i.e. round-half-up.
  - Result truncated to 16 bits.
  - est_valid = 1 at t+2, coincident with the new cfo_est.
  - State becomes TRACK at t+2.
  - phase_stb is ignored.
- TRACK:
  - cfo_est holds until the next DIVIDE.
  - Each enabled sample_stb at cycle u: ramp = wrap(ramp - cfo_est).
  - ramp_phase takes the new value and ramp_stb = 1 at u+1; ramp_stb is otherwise 0.
  - phase_stb is ignored.
- wrap(x):
  - x >= PI → x - 2*PI.
  - x < -PI → x + 2*PI.
  - Otherwise x.
  - Intermediate is 18 bits signed; |cfo_est| <= PI is guaranteed by construction, so a single correction suffices.
- enable low:
  - Freezes state, counters and outputs.
  - Strobes arriving while enable is low are lost; est_valid/ramp_stb pulses are not generated or extended during the stall.
- busy = (state == ACCUM) || (state == DIVIDE).
- Reset mid-operation: returns to reset values in the next cycle; any partial sum is discarded.

Test Plan:
1. Positive estimate: start; 16 phase_stb with phase_in = 256.
   - sum = 4096; cfo_est = 16.
   - est_valid is a single pulse 2 cycles after the 16th strobe; busy high from the cycle after start until est_valid.
2. Negative rounding: 16 strobes of phase_in = -100.
   - sum = -1600; cfo_est = -6, since (-1600+128)>>>8 = -6.
   - Also 16 strobes of -8 → sum -128 → cfo_est = 0 (half rounds up).
3. Ramp and wrap: cfo_est = 16, then 101 sample_stb.
   - ramp_phase = -16, -32, … -1600, then 1600 on the 101st (-1616 + 3216).
   - ramp_stb exactly 1 cycle after each sample_stb.
4. Restart mid-accumulation: 10 strobes of 500, then start (simultaneous with an 11th strobe), then 16 strobes of 256.
   - cfo_est = 16; no est_valid before the final 16 strobes complete.
5. Enable stall: drop enable for 5 cycles during ACCUM and during TRACK; strobes offered while low.
   - Those strobes are not counted; outputs hold; results match an unstalled run on the accepted strobes only.
6. Reset in TRACK: with cfo_est = 16 and ramp at -480, assert reset.
   - Next cycle all outputs 0, state IDLE; sample_stb then yields no ramp_stb.

Source files
------------

// File: rtl/cfo_estimate.sv
// cfo_estimate
//   Averages 2^AVG_SHIFT phase samples of the delayed autocorrelation and
//   divides by the lag to form a per-sample carrier-frequency-offset
//   increment. It then produces a wrapped derotation phase ramp, advancing
//   one step per data sample, for the rotator.
//   Phase units: radians scaled by 512, range [-PI, PI).
//
// Ports
//   clock       system clock
//   reset       synchronous, active-high
//   enable      clock enable; when low all state holds and strobes are lost
//   start       one-cycle pulse, begins a new estimate
//   phase_in    signed phase from the phase stage
//   phase_stb   phase_in valid
//   sample_stb  one data sample passed to the rotator; advances the ramp
//   busy        high while accumulating or dividing
//   cfo_est     signed per-sample phase increment
//   est_valid   one-cycle pulse when cfo_est updates
//   ramp_phase  signed derotation phase, range [-PI, PI)
//   ramp_stb    ramp_phase valid
module cfo_estimate #(
    parameter int AVG_SHIFT = 4,
    parameter int LAG_SHIFT = 4,
    parameter int PI        = 1608
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               start,
    input  logic signed [15:0] phase_in,
    input  logic               phase_stb,
    input  logic               sample_stb,
    output logic               busy,
    output logic signed [15:0] cfo_est,
    output logic               est_valid,
    output logic signed [15:0] ramp_phase,
    output logic               ramp_stb
);

    localparam int SUM_W  = 16 + AVG_SHIFT + 1;
    localparam int CNT_W  = AVG_SHIFT + 1;
    localparam int S      = AVG_SHIFT + LAG_SHIFT;
    localparam int TWO_PI = 2 * PI;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DIVIDE = 2'd2,
        TRACK  = 2'd3
    } state_t;

    state_t                   state;
    state_t                   next_state;
    logic signed [SUM_W-1:0]  sum;
    logic        [CNT_W-1:0]  count;
    logic signed [15:0]       ramp;

    logic signed [SUM_W-1:0]  rounded;
    logic signed [15:0]       cfo_next;
    logic signed [17:0]       ramp_diff;
    logic signed [17:0]       ramp_wrapped;
    logic signed [15:0]       ramp_next;
    logic                     last_strobe;

    // Round half up: bias by half an LSB of the result, then arithmetic shift.
    assign rounded  = sum + SUM_W'(1 << (S - 1));
    assign cfo_next = 16'(rounded >>> S);

    // |cfo_est| <= PI, so one correction brings the step back into range.
    always_comb begin
        ramp_diff    = 18'(ramp) - 18'(cfo_est);
        ramp_wrapped = ramp_diff;
        if (ramp_diff >= 18'(PI)) begin
            ramp_wrapped = ramp_diff - 18'(TWO_PI);
        end else if (ramp_diff < -18'(PI)) begin
            ramp_wrapped = ramp_diff + 18'(TWO_PI);
        end
    end

    assign ramp_next   = 16'(ramp_wrapped);
    assign last_strobe = phase_stb && (count == CNT_W'((1 << AVG_SHIFT) - 1));

    always_comb begin
        next_state = state;
        if (enable) begin
            if (start) begin
                next_state = ACCUM;
            end else begin
                case (state)
                    ACCUM:   if (last_strobe) next_state = DIVIDE;
                    DIVIDE:  next_state = TRACK;
                    default: next_state = state;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sum       <= '0;
            count     <= '0;
            ramp      <= '0;
            cfo_est   <= '0;
            est_valid <= 1'b0;
            ramp_stb  <= 1'b0;
        end else if (!enable) begin
            // Pulses are never stretched across a stall.
            est_valid <= 1'b0;
            ramp_stb  <= 1'b0;
        end else begin
            est_valid <= 1'b0;
            ramp_stb  <= 1'b0;
            if (start) begin
                sum   <= '0;
                count <= '0;
                ramp  <= '0;
            end else begin
                case (state)
                    ACCUM: begin
                        if (phase_stb) begin
                            sum   <= sum + SUM_W'(phase_in);
                            count <= count + CNT_W'(1);
                        end
                    end
                    DIVIDE: begin
                        cfo_est   <= cfo_next;
                        est_valid <= 1'b1;
                    end
                    TRACK: begin
                        if (sample_stb) begin
                            ramp     <= ramp_next;
                            ramp_stb <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign ramp_phase = ramp;
    assign busy       = (state == ACCUM) || (state == DIVIDE);

endmodule

// File: tb/tb_cfo_estimate.sv
// tb_cfo_estimate
//   Directed self-checking bench for cfo_estimate. Inputs change 1 time unit
//   after the rising edge; outputs are sampled at the same point.
module tb_cfo_estimate;

    logic               clock = 1'b0;
    logic               reset;
    logic               enable;
    logic               start;
    logic signed [15:0] phase_in;
    logic               phase_stb;
    logic               sample_stb;
    logic               busy;
    logic signed [15:0] cfo_est;
    logic               est_valid;
    logic signed [15:0] ramp_phase;
    logic               ramp_stb;

    int pass_cnt  = 0;
    int total_cnt = 0;

    cfo_estimate #(
        .AVG_SHIFT(4),
        .LAG_SHIFT(4),
        .PI(1608)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .start(start),
        .phase_in(phase_in),
        .phase_stb(phase_stb),
        .sample_stb(sample_stb),
        .busy(busy),
        .cfo_est(cfo_est),
        .est_valid(est_valid),
        .ramp_phase(ramp_phase),
        .ramp_stb(ramp_stb)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drives n accepted-looking phase strobes and counts est_valid pulses seen.
    task automatic feed(input int n, input logic signed [15:0] v, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            phase_in  = v;
            phase_stb = 1'b1;
            tick();
            if (est_valid) pulses++;
        end
        phase_stb = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; start = 1'b0;
        phase_in = '0; phase_stb = 1'b0; sample_stb = 1'b0;
        tick(); tick();
        reset = 1'b0;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (cfo_est !== 16'sd0) $display("FAIL reset_cfo: got %0d want 0", cfo_est); else pass_cnt++;
        total_cnt++; if (est_valid !== 1'b0) $display("FAIL reset_est_valid: got %b want 0", est_valid); else pass_cnt++;
        total_cnt++; if (ramp_phase !== 16'sd0) $display("FAIL reset_ramp: got %0d want 0", ramp_phase); else pass_cnt++;
        total_cnt++; if (ramp_stb !== 1'b0) $display("FAIL reset_ramp_stb: got %b want 0", ramp_stb); else pass_cnt++;
        // Strobes in IDLE are ignored.
        phase_in = 16'sd300; phase_stb = 1'b1; sample_stb = 1'b1;
        tick();
        phase_stb = 1'b0; sample_stb = 1'b0;
        total_cnt++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (ramp_stb !== 1'b0) $display("FAIL idle_ramp_stb: got %b want 0", ramp_stb); else pass_cnt++;
    endtask

    task automatic test_positive();
        int p;
        start = 1'b1; tick(); start = 1'b0;
        total_cnt++; if (busy !== 1'b1) $display("FAIL pos_busy_after_start: got %b want 1", busy); else pass_cnt++;
        feed(15, 16'sd256, p);
        total_cnt++; if (p !== 0) $display("FAIL pos_early_valid: got %0d pulses want 0", p); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL pos_busy_accum: got %b want 1", busy); else pass_cnt++;
        feed(1, 16'sd256, p);
        total_cnt++; if (est_valid !== 1'b0) $display("FAIL pos_valid_t1: got %b want 0", est_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL pos_busy_divide: got %b want 1", busy); else pass_cnt++;
        tick();
        total_cnt++; if (est_valid !== 1'b1) $display("FAIL pos_valid_t2: got %b want 1", est_valid); else pass_cnt++;
        total_cnt++; if (cfo_est !== 16'sd16) $display("FAIL pos_cfo: got %0d want 16", cfo_est); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL pos_busy_track: got %b want 0", busy); else pass_cnt++;
        tick();
        total_cnt++; if (est_valid !== 1'b0) $display("FAIL pos_valid_single: got %b want 0", est_valid); else pass_cnt++;
        total_cnt++; if (cfo_est !== 16'sd16) $display("FAIL pos_cfo_hold: got %0d want 16", cfo_est); else pass_cnt++;
    endtask

    task automatic test_ramp_wrap();
        logic signed [15:0] exp_r;
        // sample_stb before any TRACK-state start: still in TRACK from the previous test.
        start = 1'b1; tick(); start = 1'b0;
        total_cnt++; if (ramp_phase !== 16'sd0) $display("FAIL ramp_cleared: got %0d want 0", ramp_phase); else pass_cnt++;
        sample_stb = 1'b1; tick(); sample_stb = 1'b0;
        total_cnt++; if (ramp_stb !== 1'b0) $display("FAIL ramp_stb_in_accum: got %b want 0", ramp_stb); else pass_cnt++;
        begin int p; feed(16, 16'sd256, p); end
        tick();
        total_cnt++; if (cfo_est !== 16'sd16) $display("FAIL ramp_cfo: got %0d want 16", cfo_est); else pass_cnt++;
        for (int i = 1; i <= 101; i++) begin
            exp_r = (i <= 100) ? 16'(-16 * i) : 16'sd1600;
            sample_stb = 1'b1; tick(); sample_stb = 1'b0;
            total_cnt++; if (ramp_stb !== 1'b1) $display("FAIL ramp_stb_%0d: got %b want 1", i, ramp_stb); else pass_cnt++;
            total_cnt++; if (ramp_phase !== exp_r) $display("FAIL ramp_phase_%0d: got %0d want %0d", i, ramp_phase, exp_r); else pass_cnt++;
            tick();
            total_cnt++; if (ramp_stb !== 1'b0) $display("FAIL ramp_stb_gap_%0d: got %b want 0", i, ramp_stb); else pass_cnt++;
            total_cnt++; if (ramp_phase !== exp_r) $display("FAIL ramp_hold_%0d: got %0d want %0d", i, ramp_phase, exp_r); else pass_cnt++;
        end
    endtask

    task automatic test_negative_rounding();
        int p;
        start = 1'b1; tick(); start = 1'b0;
        feed(16, -16'sd100, p);
        tick();
        total_cnt++; if (est_valid !== 1'b1) $display("FAIL neg_valid: got %b want 1", est_valid); else pass_cnt++;
        total_cnt++; if (cfo_est !== -16'sd6) $display("FAIL neg_cfo: got %0d want -6", cfo_est); else pass_cnt++;
        start = 1'b1; tick(); start = 1'b0;
        feed(16, -16'sd8, p);
        tick();
        total_cnt++; if (est_valid !== 1'b1) $display("FAIL half_valid: got %b want 1", est_valid); else pass_cnt++;
        total_cnt++; if (cfo_est !== 16'sd0) $display("FAIL half_cfo: got %0d want 0", cfo_est); else pass_cnt++;
    endtask

    task automatic test_restart();
        int p1, p2;
        start = 1'b1; tick(); start = 1'b0;
        feed(10, 16'sd500, p1);
        start = 1'b1; phase_in = 16'sd500; phase_stb = 1'b1;
        tick();
        start = 1'b0; phase_stb = 1'b0;
        if (est_valid) p1++;
        feed(15, 16'sd256, p2);
        total_cnt++; if (p1 + p2 !== 0) $display("FAIL restart_early_valid: got %0d pulses want 0", p1 + p2); else pass_cnt++;
        feed(1, 16'sd256, p2);
        total_cnt++; if (est_valid !== 1'b0) $display("FAIL restart_valid_t1: got %b want 0", est_valid); else pass_cnt++;
        tick();
        total_cnt++; if (est_valid !== 1'b1) $display("FAIL restart_valid_t2: got %b want 1", est_valid); else pass_cnt++;
        total_cnt++; if (cfo_est !== 16'sd16) $display("FAIL restart_cfo: got %0d want 16", cfo_est); else pass_cnt++;
    endtask

    task automatic test_enable_stall();
        int p;
        start = 1'b1; tick(); start = 1'b0;
        feed(8, 16'sd512, p);
        enable = 1'b0; phase_in = 16'sd1000; phase_stb = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total_cnt++; if (busy !== 1'b1) $display("FAIL stall_accum_busy_%0d: got %b want 1", i, busy); else pass_cnt++;
            total_cnt++; if (est_valid !== 1'b0) $display("FAIL stall_accum_valid_%0d: got %b want 0", i, est_valid); else pass_cnt++;
        end
        enable = 1'b1; phase_stb = 1'b0;
        feed(7, 16'sd512, p);
        total_cnt++; if (p !== 0) $display("FAIL stall_early_valid: got %0d pulses want 0", p); else pass_cnt++;
        feed(1, 16'sd512, p);
        total_cnt++; if (busy !== 1'b1 || est_valid !== 1'b0) $display("FAIL stall_divide: got busy %b valid %b want 1 0", busy, est_valid); else pass_cnt++;
        tick();
        total_cnt++; if (est_valid !== 1'b1) $display("FAIL stall_valid: got %b want 1", est_valid); else pass_cnt++;
        total_cnt++; if (cfo_est !== 16'sd32) $display("FAIL stall_cfo: got %0d want 32", cfo_est); else pass_cnt++;
        sample_stb = 1'b1;
        tick(); tick(); tick();
        total_cnt++; if (ramp_phase !== -16'sd96) $display("FAIL stall_ramp_pre: got %0d want -96", ramp_phase); else pass_cnt++;
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total_cnt++; if (ramp_stb !== 1'b0) $display("FAIL stall_track_stb_%0d: got %b want 0", i, ramp_stb); else pass_cnt++;
            total_cnt++; if (ramp_phase !== -16'sd96) $display("FAIL stall_track_ramp_%0d: got %0d want -96", i, ramp_phase); else pass_cnt++;
            total_cnt++; if (cfo_est !== 16'sd32) $display("FAIL stall_track_cfo_%0d: got %0d want 32", i, cfo_est); else pass_cnt++;
        end
        enable = 1'b1;
        tick();
        sample_stb = 1'b0;
        total_cnt++; if (ramp_stb !== 1'b1) $display("FAIL stall_resume_stb: got %b want 1", ramp_stb); else pass_cnt++;
        total_cnt++; if (ramp_phase !== -16'sd128) $display("FAIL stall_resume_ramp: got %0d want -128", ramp_phase); else pass_cnt++;
    endtask

    task automatic test_reset_in_track();
        int p;
        start = 1'b1; tick(); start = 1'b0;
        feed(16, 16'sd256, p);
        tick();
        sample_stb = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        sample_stb = 1'b0;
        total_cnt++; if (cfo_est !== 16'sd16) $display("FAIL rst_track_cfo: got %0d want 16", cfo_est); else pass_cnt++;
        total_cnt++; if (ramp_phase !== -16'sd480) $display("FAIL rst_track_ramp: got %0d want -480", ramp_phase); else pass_cnt++;
        reset = 1'b1; sample_stb = 1'b1;
        tick();
        total_cnt++; if (cfo_est !== 16'sd0) $display("FAIL rst_cfo: got %0d want 0", cfo_est); else pass_cnt++;
        total_cnt++; if (ramp_phase !== 16'sd0) $display("FAIL rst_ramp: got %0d want 0", ramp_phase); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0 || est_valid !== 1'b0 || ramp_stb !== 1'b0) $display("FAIL rst_flags: got busy %b valid %b stb %b want 0 0 0", busy, est_valid, ramp_stb); else pass_cnt++;
        reset = 1'b0;
        tick();
        sample_stb = 1'b0;
        total_cnt++; if (ramp_stb !== 1'b0) $display("FAIL rst_idle_stb: got %b want 0", ramp_stb); else pass_cnt++;
        total_cnt++; if (ramp_phase !== 16'sd0) $display("FAIL rst_idle_ramp: got %0d want 0", ramp_phase); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_positive();
        test_ramp_wrap();
        test_negative_rounding();
        test_restart();
        test_enable_stall();
        test_reset_in_track();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
